// File: rtl/warmboot_pkg.sv
// warmboot_pkg: shared state encoding and command byte constants for the warm-boot sequencer.
package warmboot_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SETUP, BOOT} wb_state_t;
    localparam logic [7:0] CMD_ARM       = 8'hA5;
    localparam logic [7:0] CMD_TRIG      = 8'hB0;
    localparam logic [7:0] CMD_TRIG_MASK = 8'hFC;
endpackage

// File: rtl/warmboot_ctrl_btn_longpress.sv
// btn_longpress: synchronizes the raw service button and emits a one-shot pulse after a long press.
module btn_longpress #(
    parameter int unsigned LONGPRESS_CYCLES = 24_000_000
) (
    input  logic clk_24,
    input  logic rst_24_n,
    input  logic btn,
    output logic lp_fire
);
    localparam int unsigned CW = $clog2(LONGPRESS_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Fires on the cycle whose edge brings the counter to LONGPRESS_CYCLES; saturation blocks re-fire.
    always_comb begin
        sync_d  = {sync_q[0], btn};
        cnt_d   = !sync_q[1] ? '0 : (cnt_q == CW'(LONGPRESS_CYCLES)) ? cnt_q : cnt_q + CW'(1);
        lp_fire = sync_q[1] && (cnt_q == CW'(LONGPRESS_CYCLES - 1));
    end

    always_ff @(posedge clk_24 or negedge rst_24_n) begin
        if (!rst_24_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: sequences SB_WARMBOOT boot/image from armed register commands or a long button press.
module warmboot_ctrl
    import warmboot_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES     = 16,
    parameter int unsigned ARM_TIMEOUT      = 240,
    parameter int unsigned LONGPRESS_CYCLES = 24_000_000,
    parameter logic [1:0]  BTN_IMAGE        = 2'd0
) (
    input  logic       clk_24,
    input  logic       rst_24_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       btn,
    output logic [1:0] image,
    output logic       boot,
    output logic       armed,
    output logic       busy
);
    localparam int unsigned SW = $clog2(SETUP_CYCLES + 1);
    localparam int unsigned AW = $clog2(ARM_TIMEOUT + 1);

    wb_state_t     state_q, state_d;
    logic [SW-1:0] setup_cnt_q, setup_cnt_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic [1:0]    image_q, image_d;
    logic          boot_q, boot_d, armed_q, armed_d, busy_q, busy_d;
    logic          lp_fire, hs, is_arm, is_trig;

    btn_longpress #(.LONGPRESS_CYCLES(LONGPRESS_CYCLES)) u_btn (
        .clk_24  (clk_24),
        .rst_24_n(rst_24_n),
        .btn     (btn),
        .lp_fire (lp_fire)
    );

    assign cmd_ready = (state_q == IDLE) || (state_q == ARMED);

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        arm_cnt_d   = arm_cnt_q;
        image_d     = image_q;
        hs          = cmd_valid && cmd_ready;
        is_arm      = cmd_data == CMD_ARM;
        is_trig     = (cmd_data & CMD_TRIG_MASK) == CMD_TRIG;
        case (state_q)
            IDLE, ARMED: begin
                // The button outranks any byte handshaking on the same edge.
                if (lp_fire) begin
                    state_d     = SETUP;
                    image_d     = BTN_IMAGE;
                    setup_cnt_d = '0;
                end else if (hs && is_trig && state_q == ARMED) begin
                    state_d     = SETUP;
                    image_d     = cmd_data[1:0];
                    setup_cnt_d = '0;
                end else if (hs && is_arm) begin
                    state_d   = ARMED;
                    arm_cnt_d = '0;
                end else if (hs || state_q == IDLE) begin
                    state_d = IDLE;
                end else if (arm_cnt_q == AW'(ARM_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            SETUP: begin
                if (setup_cnt_q == SW'(SETUP_CYCLES - 1)) state_d = BOOT;
                else setup_cnt_d = setup_cnt_q + SW'(1);
            end
            default: ;
        endcase
        armed_d = state_d == ARMED;
        busy_d  = state_d == SETUP || state_d == BOOT;
        boot_d  = state_d == BOOT;
    end

    always_ff @(posedge clk_24 or negedge rst_24_n) begin
        if (!rst_24_n) begin
            state_q     <= IDLE;
            setup_cnt_q <= '0;
            arm_cnt_q   <= '0;
            image_q     <= '0;
            boot_q      <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            image_q     <= image_d;
            boot_q      <= boot_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
        end
    end

    assign image = image_q;
    assign boot  = boot_q;
    assign armed = armed_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb_warmboot_ctrl: directed vector table plus hand sequences for arm/trigger, timeout, button and reset.
module tb_warmboot_ctrl;
    logic       clk_24 = 1'b0;
    logic       rst_24_n, cmd_valid, cmd_ready, btn, boot, armed, busy;
    logic [7:0] cmd_data;
    logic [1:0] image;
    int         checks = 0, failures = 0;

    // Expected output word {cmd_ready, armed, busy, boot, image}.
    localparam logic [5:0] O_IDLE  = 6'b100000;
    localparam logic [5:0] O_ARMED = 6'b110000;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [5:0] exp;
    } vec_t;
    vec_t tv[7];

    warmboot_ctrl #(.LONGPRESS_CYCLES(100)) dut (
        .clk_24   (clk_24),
        .rst_24_n (rst_24_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .btn      (btn),
        .image    (image),
        .boot     (boot),
        .armed    (armed),
        .busy     (busy)
    );

    always #5 clk_24 = ~clk_24;

    function automatic logic [5:0] outs();
        return {cmd_ready, armed, busy, boot, image};
    endfunction

    function automatic logic [5:0] o_setup(logic [1:0] i);
        return {4'b0010, i};
    endfunction

    function automatic logic [5:0] o_boot(logic [1:0] i);
        return {4'b0011, i};
    endfunction

    task automatic chk(string n, logic [5:0] act, logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (ready,armed,busy,boot,image)", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_24);
        #1;
    endtask

    task automatic send(logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic do_reset(string n);
        #2 rst_24_n = 1'b0;
        cmd_valid = 1'b0;
        btn = 1'b0;
        #1 chk(n, outs(), O_IDLE);
        #1 rst_24_n = 1'b1;
    endtask

    initial begin
        rst_24_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = 8'h00;
        btn = 1'b0;
        tv[0] = '{1'b0, 8'h00, O_IDLE};
        tv[1] = '{1'b1, 8'h3C, O_IDLE};
        tv[2] = '{1'b1, 8'hA5, O_ARMED};
        tv[3] = '{1'b1, 8'h3C, O_IDLE};
        tv[4] = '{1'b1, 8'hA5, O_ARMED};
        tv[5] = '{1'b1, 8'hB2, 6'b001010};
        tv[6] = '{1'b1, 8'hA5, 6'b001010};
        #12 chk("reset", outs(), O_IDLE);
        rst_24_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cmd_valid = tv[i].v;
            cmd_data  = tv[i].d;
            step();
            cmd_valid = 1'b0;
            chk($sformatf("vec%0d", i), outs(), tv[i].exp);
        end
        for (int j = 2; j <= 16; j++) begin
            step();
            chk($sformatf("setup_b2_e%0d", j), outs(), j == 16 ? o_boot(2'd2) : o_setup(2'd2));
        end
        for (int j = 0; j < 1000; j++) begin
            step();
            if (j % 100 == 99) chk("boot_hold", outs(), o_boot(2'd2));
        end
        do_reset("rst_in_boot");

        send(8'hA5);
        chk("rearm1", outs(), O_ARMED);
        send(8'hA5);
        chk("rearm2", outs(), O_ARMED);
        idle(200);
        chk("armed_200", outs(), O_ARMED);
        send(8'hB3);
        chk("trig_b3", outs(), o_setup(2'd3));
        idle(16);
        chk("boot_b3", outs(), o_boot(2'd3));
        do_reset("rst_boot_b3");

        send(8'hA5);
        for (int j = 1; j <= 240; j++) begin
            step();
            if (j == 239) chk("armed_239", outs(), O_ARMED);
            if (j == 240) chk("timeout_240", outs(), O_IDLE);
        end
        send(8'hB1);
        chk("trig_dropped", outs(), O_IDLE);
        idle(20);
        chk("no_boot", outs(), O_IDLE);

        send(8'hA5);
        idle(239);
        chk("pre_timeout", outs(), O_ARMED);
        send(8'hB1);
        chk("trig_on_timeout", outs(), o_setup(2'd1));
        idle(16);
        chk("boot_b1", outs(), o_boot(2'd1));
        do_reset("rst_boot_b1");

        btn = 1'b1;
        for (int j = 1; j <= 102; j++) begin
            if (j == 50) begin cmd_valid = 1'b1; cmd_data = 8'hA5; end
            if (j == 102) begin
                cmd_valid = 1'b1;
                cmd_data = 8'hB1;
                chk("ready_at_fire", {5'b0, cmd_ready}, 6'b000001);
            end
            step();
            cmd_valid = 1'b0;
            if (j == 50) chk("armed_pre_fire", outs(), O_ARMED);
            if (j == 101) chk("no_fire_101", outs(), O_ARMED);
            if (j == 102) chk("btn_wins", outs(), o_setup(2'd0));
        end
        idle(5);
        chk("mid_setup", outs(), o_setup(2'd0));
        do_reset("rst_in_setup");

        btn = 1'b1;
        idle(90);
        btn = 1'b0;
        chk("short_press", outs(), O_IDLE);
        idle(5);
        chk("short_release", outs(), O_IDLE);
        btn = 1'b1;
        for (int j = 1; j <= 120; j++) begin
            step();
            if (j == 101) chk("lp_101", outs(), O_IDLE);
            if (j == 102) chk("lp_fire", outs(), o_setup(2'd0));
            if (j == 117) chk("lp_setup_117", outs(), o_setup(2'd0));
            if (j == 118) chk("lp_boot_118", outs(), o_boot(2'd0));
        end
        btn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
